// File: rtl/bdd_eval_engine.sv
// Table-driven multi-output ROBDD evaluator.
// Walks one node per cycle; one result per accepted input vector.
module bdd_eval_engine #(
  parameter int IN_W       = 1894,
  parameter int N_OUT      = 8,
  parameter int NODE_DEPTH = 256,
  parameter int MAX_STEPS  = 64,
  localparam int VAR_W  = $clog2(IN_W),
  localparam int PTR_W  = $clog2(NODE_DEPTH),
  localparam int CH_W   = PTR_W + 1,
  localparam int NODE_W = VAR_W + 2 * CH_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_root,
  input  logic [PTR_W-1:0]  cfg_addr,
  input  logic [NODE_W-1:0] cfg_data,
  output logic              cfg_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_bits,
  output logic              out_err
);

  localparam int K_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [NODE_W-1:0] node_q [NODE_DEPTH];
  logic [CH_W-1:0]   root_q [N_OUT];
  logic [IN_W-1:0]   vec_q;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [N_OUT-1:0]  bits_q, bits_d;
  logic              err_q, err_d;

  logic              pend_q;
  logic              pend_root_q;
  logic [PTR_W-1:0]  pend_addr_q;
  logic [NODE_W-1:0] pend_data_q;

  logic              idle, accept, release_r, commit;
  logic              wr_en, wr_root;
  logic [PTR_W-1:0]  wr_addr;
  logic [NODE_W-1:0] wr_data;

  logic [NODE_W-1:0] cur;
  logic [VAR_W-1:0]  nvar;
  logic [CH_W-1:0]   nlo, nhi;
  logic              var_bad;

  assign idle      = (state_q == S_IDLE);
  assign accept    = idle && in_valid;
  assign release_r = (state_q == S_DONE) && out_ready;

  // A write colliding with accept is parked so the walk sees old tables
  assign commit  = pend_q && (rst || release_r);
  assign wr_en   = (idle && cfg_we && !accept && !rst) || commit;
  assign wr_root = commit ? pend_root_q : cfg_root;
  assign wr_addr = commit ? pend_addr_q : cfg_addr;
  assign wr_data = commit ? pend_data_q : cfg_data;

  always_ff @(posedge clk) begin
    if (wr_en && !wr_root) node_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OUT; i++)
        root_q[i] <= {1'b1, {(CH_W-1){1'b0}}};
    end else if (wr_en && wr_root && (32'(wr_addr) < N_OUT)) begin
      root_q[wr_addr[K_W-1:0]] <= wr_data[CH_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else if (accept && cfg_we) pend_q <= 1'b1;
    else if (release_r) pend_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept && cfg_we) begin
      pend_root_q <= cfg_root;
      pend_addr_q <= cfg_addr;
      pend_data_q <= cfg_data;
    end
    if (accept) vec_q <= in_vec;
  end

  assign cur     = node_q[ptr_q[PTR_W-1:0]];
  assign nvar    = cur[NODE_W-1 -: VAR_W];
  assign nlo     = cur[2*CH_W-1 -: CH_W];
  assign nhi     = cur[CH_W-1:0];
  assign var_bad = (32'(nvar) >= IN_W);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    k_d     = k_q;
    steps_d = steps_q;
    bits_d  = bits_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_WALK;
          k_d     = '0;
          ptr_d   = root_q[0];
          steps_d = '0;
          err_d   = 1'b0;
        end
      end
      S_WALK: begin
        if (ptr_q[CH_W-1]) begin
          bits_d[k_q] = ptr_q[0];
          if (k_q == K_W'(N_OUT - 1)) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + K_W'(1);
            ptr_d   = root_q[k_d];
            steps_d = '0;
          end
        end else if (var_bad || steps_q == STEP_W'(MAX_STEPS)) begin
          err_d   = 1'b1;
          bits_d  = '0;
          state_d = S_DONE;
        end else begin
          ptr_d   = vec_q[nvar] ? nhi : nlo;
          steps_d = steps_q + STEP_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      k_q     <= '0;
      steps_q <= '0;
      bits_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
      steps_q <= steps_d;
      bits_q  <= bits_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready = idle;
  assign in_ready  = idle;
  assign out_valid = (state_q == S_DONE);
  assign out_bits  = bits_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_bdd_eval_engine.sv
// Randomized bench for bdd_eval_engine.
// Results and latency come from a path-walking reference model.
module tb_bdd_eval_engine;

  localparam int IN_W       = 1894;
  localparam int N_OUT      = 8;
  localparam int NODE_DEPTH = 256;
  localparam int MAX_STEPS  = 64;
  localparam int VAR_W  = $clog2(IN_W);
  localparam int PTR_W  = $clog2(NODE_DEPTH);
  localparam int CH_W   = PTR_W + 1;
  localparam int NODE_W = VAR_W + 2 * CH_W;
  localparam int BUDGET = N_OUT * (MAX_STEPS + 1) + 8;

  localparam logic [CH_W-1:0] T0 = 9'h100;
  localparam logic [CH_W-1:0] T1 = 9'h101;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we, cfg_root;
  logic [PTR_W-1:0]  cfg_addr;
  logic [NODE_W-1:0] cfg_data;
  logic              cfg_ready;
  logic              in_valid, in_ready;
  logic [IN_W-1:0]   in_vec;
  logic              out_valid, out_ready;
  logic [N_OUT-1:0]  out_bits;
  logic              out_err;

  bdd_eval_engine #(
    .IN_W(IN_W), .N_OUT(N_OUT),
    .NODE_DEPTH(NODE_DEPTH), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_root(cfg_root),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int              m_var  [NODE_DEPTH];
  logic [CH_W-1:0] m_lo   [NODE_DEPTH];
  logic [CH_W-1:0] m_hi   [NODE_DEPTH];
  logic [CH_W-1:0] m_root [N_OUT];

  logic              pw_root;
  logic [PTR_W-1:0]  pw_addr;
  logic [NODE_W-1:0] pw_data;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset_roots();
    for (int i = 0; i < N_OUT; i++) m_root[i] = T0;
  endfunction

  function automatic void model_write(input logic r,
      input logic [PTR_W-1:0] a, input logic [NODE_W-1:0] d);
    if (r) begin
      if (int'(a) < N_OUT) m_root[a] = d[CH_W-1:0];
    end else begin
      m_var[a] = int'(d[NODE_W-1 -: VAR_W]);
      m_lo[a]  = d[2*CH_W-1 -: CH_W];
      m_hi[a]  = d[CH_W-1:0];
    end
  endfunction

  // Follows each output's path; one cycle per visited node plus one per terminal
  function automatic void model(input logic [IN_W-1:0] v,
      output logic [N_OUT-1:0] b, output bit e, output int lat);
    logic [CH_W-1:0] p;
    int visits, n;
    b = '0; e = 0; lat = 0;
    for (int k = 0; k < N_OUT; k++) begin
      p = m_root[k];
      visits = 0;
      while (1) begin
        if (p[CH_W-1]) begin
          b[k] = p[0];
          lat += visits + 1;
          break;
        end
        n = int'(p[PTR_W-1:0]);
        if (m_var[n] >= IN_W || visits == MAX_STEPS) begin
          e = 1; b = '0;
          lat += visits + 1;
          return;
        end
        p = v[m_var[n]] ? m_hi[n] : m_lo[n];
        visits++;
      end
    end
  endfunction

  function automatic logic [IN_W-1:0] rand_vec();
    logic [IN_W-1:0] v;
    for (int i = 0; i < IN_W; i++) v[i] = 1'($urandom_range(1, 0));
    return v;
  endfunction

  task automatic wr(input logic r, input logic [PTR_W-1:0] a,
                    input logic [NODE_W-1:0] d);
    cfg_we = 1; cfg_root = r; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 0;
    model_write(r, a, d);
  endtask

  task automatic wr_node(input int idx, input int vr,
      input logic [CH_W-1:0] lo, input logic [CH_W-1:0] hi);
    wr(1'b0, PTR_W'(idx), {VAR_W'(vr), lo, hi});
  endtask

  task automatic wr_root(input int idx, input logic [CH_W-1:0] ch);
    wr(1'b1, PTR_W'(idx), NODE_W'(ch));
  endtask

  // mode 0: plain, 1: cfg pulse during walk, 2: cfg write at accept
  task automatic run_vec(input logic [IN_W-1:0] v, input int hold,
                         input int mode);
    logic [N_OUT-1:0] eb;
    bit ee;
    int el, lat;
    model(v, eb, ee, el);
    chk("in_ready_idle", in_ready, 1);
    chk("cfg_ready_idle", cfg_ready, 1);
    in_valid = 1; in_vec = v;
    if (mode == 2) begin
      cfg_we = 1; cfg_root = pw_root;
      cfg_addr = pw_addr; cfg_data = pw_data;
    end
    @(negedge clk);
    in_valid = 0; cfg_we = 0;
    if (mode == 2) model_write(pw_root, pw_addr, pw_data);
    chk("in_ready_busy", in_ready, 0);
    chk("cfg_ready_busy", cfg_ready, 0);
    lat = 0;
    while (!out_valid && lat < BUDGET) begin
      if (mode == 1 && lat == 0) begin
        cfg_we = 1; cfg_root = pw_root;
        cfg_addr = pw_addr; cfg_data = pw_data;
      end
      @(negedge clk);
      cfg_we = 0;
      lat++;
    end
    chk("out_valid_timeout", out_valid, 1);
    chk("latency", lat, el);
    chk("out_bits", out_bits, eb);
    chk("out_err", out_err, ee);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_bits", out_bits, eb);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("release_err", out_err, 0);
  endtask

  function automatic logic [CH_W-1:0] rand_child(input int i);
    int r;
    r = int'($urandom_range(99, 0));
    if (r < 3) return CH_W'($urandom_range(NODE_DEPTH - 1, 0));
    if (r < 50 || i >= NODE_DEPTH - 1) return {1'b1, 7'd0, 1'($urandom_range(1, 0))};
    return CH_W'($urandom_range(NODE_DEPTH - 1, i + 1));
  endfunction

  initial begin
    logic [IN_W-1:0] v;
    int vr;
    rst = 1; cfg_we = 0; cfg_root = 0; cfg_addr = '0; cfg_data = '0;
    in_valid = 0; in_vec = '0; out_ready = 0;
    model_reset_roots();
    for (int i = 0; i < NODE_DEPTH; i++) begin
      m_var[i] = 0; m_lo[i] = T0; m_hi[i] = T0;
    end
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_out_err", out_err, 0);

    run_vec(rand_vec(), 0, 0);

    wr_node(0, 79, T0, CH_W'(1));
    wr_node(1, 1722, T0, T1);
    wr_root(0, CH_W'(0));
    v = rand_vec(); v[79] = 1; v[1722] = 1;
    run_vec(v, 0, 0);
    v[1722] = 0;
    run_vec(v, 0, 0);

    v[1722] = 1;
    run_vec(v, 5, 0);
    pw_root = 1; pw_addr = '0; pw_data = NODE_W'(T1);
    run_vec(v, 0, 1);
    run_vec(v, 0, 0);

    wr_node(2, 5, CH_W'(2), CH_W'(2));
    wr_root(1, CH_W'(2));
    run_vec(rand_vec(), 2, 0);

    in_valid = 1; in_vec = v;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_err", out_err, 0);
    rst = 0;
    model_reset_roots();
    wr_root(0, CH_W'(0));
    run_vec(v, 0, 0);

    wr_node(3, IN_W, T0, T1);
    wr_root(2, CH_W'(3));
    run_vec(rand_vec(), 0, 0);
    wr_root(2, T1);

    pw_root = 1; pw_addr = '0; pw_data = NODE_W'(T1);
    run_vec(v, 0, 2);
    run_vec(v, 0, 0);

    for (int i = 0; i < NODE_DEPTH; i++) begin
      vr = ($urandom_range(19, 0) == 0) ?
           int'($urandom_range(2047, IN_W)) :
           int'($urandom_range(IN_W - 1, 0));
      wr_node(i, vr, rand_child(i), rand_child(i));
    end
    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 0) begin
        for (int k = 0; k < N_OUT; k++)
          wr_root(k, ($urandom_range(4, 0) == 0) ?
                     {1'b1, 7'd0, 1'($urandom_range(1, 0))} :
                     CH_W'($urandom_range(63, 0)));
      end
      if (t % 5 == 3) begin
        pw_root = 1'($urandom_range(1, 0));
        pw_addr = PTR_W'($urandom_range(pw_root ? N_OUT - 1 : 63, 0));
        pw_data = {VAR_W'($urandom_range(IN_W - 1, 0)),
                   rand_child(int'(pw_addr)), rand_child(int'(pw_addr))};
        run_vec(rand_vec(), int'($urandom_range(2, 0)),
                int'($urandom_range(2, 1)));
      end else begin
        run_vec(rand_vec(), int'($urandom_range(2, 0)), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
